vector_lane_sequencer: RTL and testbench

//  Upstream element sequencer for one vector lane. Accepts a vector op, walks element

---
 rtl/vector_lane_sequencer_if.sv | 60 ++++++
 rtl/vector_lane_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vector_lane_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_lane_sequencer_if.sv
// Handshake and data bundle between the vector lane sequencer (master) and its
// register file / lane / writeback environment (slave). VLANE_SEQ_PERF_EN adds stall_cnt.
interface vector_lane_sequencer_if #(
    parameter int VLMAX  = 32,
    parameter int IDX_W  = $clog2(VLMAX),
    parameter int DATA_W = 32
);
    logic              start;
    logic              ready;
    logic [IDX_W:0]    vl;
    logic              vm;
    logic              flush;
    logic              rf_ren;
    logic [IDX_W-1:0]  rf_idx;
    logic [DATA_W-1:0] rf_vs1;
    logic [DATA_W-1:0] rf_vs2;
    logic [DATA_W-1:0] rf_vs3;
    logic              rf_mask_bit;
    logic [DATA_W-1:0] lane_vs1;
    logic [DATA_W-1:0] lane_vs2;
    logic [DATA_W-1:0] lane_vs3;
    logic              lane_mask;
    logic              lane_start;
    logic              lane_busy;
    logic [DATA_W-1:0] lane_result;
    logic              lane_exception;
    logic              wb_en;
    logic [IDX_W-1:0]  wb_idx;
    logic [DATA_W-1:0] wb_data;
    logic              done;
    logic              exc;
    logic [IDX_W-1:0]  exc_idx;
`ifdef VLANE_SEQ_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    modport master (
        input  start, vl, vm, flush,
        input  rf_vs1, rf_vs2, rf_vs3, rf_mask_bit,
        input  lane_busy, lane_result, lane_exception,
        output ready, rf_ren, rf_idx,
        output lane_vs1, lane_vs2, lane_vs3, lane_mask, lane_start,
        output wb_en, wb_idx, wb_data, done, exc, exc_idx
`ifdef VLANE_SEQ_PERF_EN
        , output stall_cnt
`endif
    );

    modport slave (
        output start, vl, vm, flush,
        output rf_vs1, rf_vs2, rf_vs3, rf_mask_bit,
        output lane_busy, lane_result, lane_exception,
        input  ready, rf_ren, rf_idx,
        input  lane_vs1, lane_vs2, lane_vs3, lane_mask, lane_start,
        input  wb_en, wb_idx, wb_data, done, exc, exc_idx
`ifdef VLANE_SEQ_PERF_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/vector_lane_sequencer.sv
// Element sequencer for one vector lane: read -> issue -> wait -> writeback per element.
// Optional WAIT-stall counter enabled by defining VLANE_SEQ_PERF_EN.
module vector_lane_sequencer #(
    parameter int VLMAX  = 32,
    parameter int IDX_W  = $clog2(VLMAX),
    parameter int DATA_W = 32
) (
    input logic                     clk,
    input logic                     rst,
    vector_lane_sequencer_if.master bus
);
    localparam logic [IDX_W:0] VL_MAX = (IDX_W+1)'(VLMAX);
    localparam logic [IDX_W:0] VL_ONE = (IDX_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  exc_idx_q;
    logic [IDX_W:0]    vl_q;
    logic [IDX_W:0]    vl_eff;
    logic              vm_q;
    logic [DATA_W-1:0] vs1_p1;
    logic [DATA_W-1:0] vs2_p1;
    logic [DATA_W-1:0] vs3_p1;
    logic              mask_p1;
    logic [DATA_W-1:0] result_p2;
    logic              exc_p2;
    logic              accept;
    logic              last_elem;
    logic              lane_fault;

    function automatic logic [IDX_W:0] clamp_vl(input logic [IDX_W:0] v);
        return (v > VL_MAX) ? VL_MAX : v;
    endfunction

    assign vl_eff     = clamp_vl(bus.vl);
    assign accept     = (state == S_IDLE) && bus.start && !bus.flush;
    // vl_q >= 1 whenever WB is reached, so the IDX_W+1 compare cannot wrap.
    assign last_elem  = ({1'b0, idx} == (vl_q - VL_ONE));
    // Exceptions from masked-off elements are dropped.
    assign lane_fault = !bus.lane_busy && bus.lane_exception && mask_p1;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.ready      = 1'b0;
        bus.rf_ren     = 1'b0;
        bus.rf_idx     = '0;
        bus.lane_start = 1'b0;
        bus.wb_en      = 1'b0;
        bus.wb_idx     = '0;
        bus.wb_data    = '0;
        bus.done       = 1'b0;
        bus.exc        = 1'b0;
        bus.exc_idx    = '0;
        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (accept) state_nxt = (vl_eff == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                bus.rf_ren = 1'b1;
                bus.rf_idx = idx;
                state_nxt  = S_ISSUE;
            end
            S_ISSUE: begin
                bus.lane_start = 1'b1;
                state_nxt      = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.lane_busy) state_nxt = lane_fault ? S_DONE : S_WB;
            end
            S_WB: begin
                bus.wb_en   = mask_p1;
                bus.wb_idx  = idx;
                bus.wb_data = result_p2;
                state_nxt   = last_elem ? S_DONE : S_READ;
            end
            S_DONE: begin
                bus.done    = 1'b1;
                bus.exc     = exc_p2;
                bus.exc_idx = exc_p2 ? exc_idx_q : '0;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.flush) state_nxt = S_IDLE;
    end

    assign bus.lane_vs1  = vs1_p1;
    assign bus.lane_vs2  = vs2_p1;
    assign bus.lane_vs3  = vs3_p1;
    assign bus.lane_mask = mask_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            vl_q      <= '0;
            vm_q      <= 1'b0;
            vs1_p1    <= '0;
            vs2_p1    <= '0;
            vs3_p1    <= '0;
            mask_p1   <= 1'b0;
            result_p2 <= '0;
            exc_p2    <= 1'b0;
            exc_idx_q <= '0;
        end else begin
            if (accept) begin
                vl_q   <= vl_eff;
                vm_q   <= bus.vm;
                idx    <= '0;
                exc_p2 <= 1'b0;
            end
            // p1: register-file data arrives the cycle after rf_ren
            if (state == S_ISSUE) begin
                vs1_p1  <= bus.rf_vs1;
                vs2_p1  <= bus.rf_vs2;
                vs3_p1  <= bus.rf_vs3;
                mask_p1 <= vm_q | bus.rf_mask_bit;
            end
            // p2: lane result captured once busy drops
            if (state == S_WAIT && !bus.lane_busy) begin
                result_p2 <= bus.lane_result;
                if (lane_fault) begin
                    exc_p2    <= 1'b1;
                    exc_idx_q <= idx;
                end
            end
            if (state == S_WB && !last_elem) idx <= idx + IDX_W'(1);
        end
    end

`ifdef VLANE_SEQ_PERF_EN
    logic [15:0] stall_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)                                   stall_cnt_q <= '0;
        else if (accept)                           stall_cnt_q <= '0;
        else if (state == S_WAIT && bus.lane_busy) stall_cnt_q <= sat_inc16(stall_cnt_q);
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Bench for vector_lane_sequencer: directed scenarios plus randomized ops against an
// element-list reference model; register file and lane are modelled by the bench.
module tb_vector_lane_sequencer;
    localparam int VLMAX = 32;
    localparam int VW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    vector_lane_sequencer_if bus ();
    vector_lane_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] rf1 [VLMAX];
    logic [31:0] rf2 [VLMAX];
    logic [31:0] rf3 [VLMAX];
    logic        mk  [VLMAX];
    int          busy_plan [VLMAX];
    bit          exc_plan  [VLMAX];

    int          cyc = 0;
    int          op_vl = 0;
    int          reads, starts, done_cnt, done_cyc, exc_idx_o;
    bit          exc_o, tail_bad, lane_start_now;
    int          wr_idx[$];
    logic [31:0] wr_data[$];
    bit          rd_pend = 1'b0;
    int          pend_idx = 0;
    bit          lw = 1'b0;
    int          busy_rem = 0;
    int          cur_el = 0;

    function automatic logic [31:0] lane_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return a + (b ^ c);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_log();
        reads = 0; starts = 0; done_cnt = 0; done_cyc = 0; exc_idx_o = 0;
        exc_o = 1'b0; tail_bad = 1'b0;
        wr_idx.delete(); wr_data.delete();
    endtask

    // One clock: observe this cycle's outputs, then drive the RF and lane responses.
    task automatic step();
        @(posedge clk); #1;
        cyc++;
        lane_start_now = bus.lane_start;
        if (bus.rf_ren) begin
            reads++;
            if (int'(bus.rf_idx) >= op_vl) tail_bad = 1'b1;
        end
        if (bus.lane_start) starts++;
        if (bus.wb_en) begin
            wr_idx.push_back(int'(bus.wb_idx));
            wr_data.push_back(bus.wb_data);
        end
        if (bus.done) begin
            done_cnt++; done_cyc = cyc; exc_o = bus.exc; exc_idx_o = int'(bus.exc_idx);
        end
        if (rd_pend) begin
            bus.rf_vs1 = rf1[pend_idx]; bus.rf_vs2 = rf2[pend_idx];
            bus.rf_vs3 = rf3[pend_idx]; bus.rf_mask_bit = mk[pend_idx];
        end else begin
            bus.rf_vs1 = $urandom; bus.rf_vs2 = $urandom; bus.rf_vs3 = $urandom;
            bus.rf_mask_bit = 1'($urandom_range(0, 1));
        end
        rd_pend  = bus.rf_ren;
        pend_idx = int'(bus.rf_idx);
        bus.lane_busy      = 1'b0;
        bus.lane_result    = $urandom;
        bus.lane_exception = 1'($urandom_range(0, 1));
        if (lw) begin
            if (busy_rem > 0) begin
                bus.lane_busy = 1'b1;
                busy_rem--;
            end else begin
                bus.lane_result    = lane_fn(bus.lane_vs1, bus.lane_vs2, bus.lane_vs3);
                bus.lane_exception = exc_plan[cur_el];
                lw = 1'b0;
            end
        end
        if (bus.lane_start) begin
            lw = 1'b1;
            cur_el = (starts - 1) % VLMAX;
            busy_rem = busy_plan[cur_el];
        end
    endtask

    task automatic fill(input bit mask_rand, input bit plan_rand);
        for (int i = 0; i < VLMAX; i++) begin
            rf1[i] = $urandom; rf2[i] = $urandom; rf3[i] = $urandom;
            mk[i] = mask_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            busy_plan[i] = (plan_rand && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, 4)) : 0;
            exc_plan[i]  = plan_rand && ($urandom_range(0, 9) == 0);
        end
    endtask

    task automatic do_op(input int vl_in, input bit vm_in, input int flush_elem,
                         input bit noise, input string tag);
        int clampv, exp_starts, exp_lat, exp_stall, exp_exc_idx, guard, c0, pre_wr, n;
        bit exp_exc, stop, flushed, eff;
        int exp_widx[$];
        logic [31:0] exp_wdata[$];
        clampv = (vl_in > VLMAX) ? VLMAX : vl_in;
        exp_starts = 0; exp_lat = 1; exp_stall = 0; exp_exc = 1'b0; exp_exc_idx = 0; stop = 1'b0;
        pre_wr = 0;
        for (int i = 0; i < clampv; i++) begin
            if (!stop) begin
                eff = vm_in | mk[i];
                if (i < flush_elem && eff) pre_wr++;
                exp_starts++;
                exp_lat   += 4 + busy_plan[i];
                exp_stall += busy_plan[i];
                if (eff && exc_plan[i]) begin
                    exp_exc = 1'b1; exp_exc_idx = i; exp_lat -= 1; stop = 1'b1;
                end else if (eff) begin
                    exp_widx.push_back(i);
                    exp_wdata.push_back(lane_fn(rf1[i], rf2[i], rf3[i]));
                end
            end
        end
        reset_log();
        op_vl = clampv;
        chk({tag, "_ready_in"}, 64'(bus.ready), 64'd1);
        bus.vl = VW'(vl_in); bus.vm = vm_in; bus.start = 1'b1;
        c0 = cyc; guard = 0; flushed = 1'b0;
        while (done_cnt == 0 && !flushed && guard < 1200) begin
            step();
            guard++;
            if (flush_elem >= 0 && lane_start_now && starts == flush_elem + 1) begin
                bus.start = 1'b0;
                step();
                bus.flush = 1'b1;
                step();
                bus.flush = 1'b0;
                flushed = 1'b1;
            end else if (noise && done_cnt == 0 && !bus.ready) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.vl = VW'($urandom);
                bus.vm = 1'($urandom_range(0, 1));
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0; bus.vl = VW'(vl_in); bus.vm = vm_in;
        if (flushed) begin
            chk({tag, "_ready_after_flush"}, 64'(bus.ready), 64'd1);
            op_vl = 0;
            repeat (8) step();
            chk({tag, "_no_done"}, 64'(done_cnt), 64'd0);
            chk({tag, "_wr_cnt"}, 64'(wr_idx.size()), 64'(pre_wr));
            chk({tag, "_reads"}, 64'(reads), 64'(flush_elem + 1));
            chk({tag, "_starts"}, 64'(starts), 64'(flush_elem + 1));
        end else begin
            chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
            chk({tag, "_latency"}, 64'(done_cyc - c0), 64'(exp_lat));
            chk({tag, "_exc"}, 64'(exc_o), 64'(exp_exc));
            if (exp_exc) chk({tag, "_exc_idx"}, 64'(exc_idx_o), 64'(exp_exc_idx));
            chk({tag, "_wr_cnt"}, 64'(wr_idx.size()), 64'(exp_widx.size()));
            n = (wr_idx.size() < exp_widx.size()) ? wr_idx.size() : exp_widx.size();
            for (int i = 0; i < n; i++) begin
                chk({tag, "_wb_idx"}, 64'(wr_idx[i]), 64'(exp_widx[i]));
                chk({tag, "_wb_data"}, 64'(wr_data[i]), 64'(exp_wdata[i]));
            end
            chk({tag, "_starts"}, 64'(starts), 64'(exp_starts));
            chk({tag, "_reads"}, 64'(reads), 64'(exp_starts));
            chk({tag, "_tail_read"}, 64'(tail_bad), 64'd0);
`ifdef VLANE_SEQ_PERF_EN
            chk({tag, "_stall"}, 64'(bus.stall_cnt), 64'(exp_stall));
`endif
            op_vl = 0;
            step();
            chk({tag, "_ready_after"}, 64'(bus.ready), 64'd1);
            chk({tag, "_single_done"}, 64'(done_cnt), 64'd1);
`ifdef VLANE_SEQ_PERF_EN
            chk({tag, "_stall_held"}, 64'(bus.stall_cnt), 64'(exp_stall));
`endif
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(bus.ready), 64'd1);
        chk({tag, "_rf_ren"}, 64'(bus.rf_ren), 64'd0);
        chk({tag, "_rf_idx"}, 64'(bus.rf_idx), 64'd0);
        chk({tag, "_lane_start"}, 64'(bus.lane_start), 64'd0);
        chk({tag, "_lane_vs1"}, 64'(bus.lane_vs1), 64'd0);
        chk({tag, "_lane_mask"}, 64'(bus.lane_mask), 64'd0);
        chk({tag, "_wb_en"}, 64'(bus.wb_en), 64'd0);
        chk({tag, "_wb_data"}, 64'(bus.wb_data), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_exc"}, 64'(bus.exc), 64'd0);
`ifdef VLANE_SEQ_PERF_EN
        chk({tag, "_stall"}, 64'(bus.stall_cnt), 64'd0);
`endif
    endtask

    initial begin
        bus.start = 1'b0; bus.vl = '0; bus.vm = 1'b0; bus.flush = 1'b0;
        bus.rf_vs1 = '0; bus.rf_vs2 = '0; bus.rf_vs3 = '0; bus.rf_mask_bit = 1'b0;
        bus.lane_busy = 1'b0; bus.lane_result = '0; bus.lane_exception = 1'b0;
        reset_log();
        fill(1'b0, 1'b0);
        rst = 1'b1;
        repeat (3) step();
        check_reset_outputs("reset");
        rst = 1'b0;
        step();

        fill(1'b0, 1'b0);
        do_op(4, 1'b1, -1, 1'b0, "vl4");

        do_op(0, 1'b1, -1, 1'b0, "vl0");

        fill(1'b0, 1'b0);
        mk[0] = 1'b1; mk[1] = 1'b0; mk[2] = 1'b1;
        do_op(3, 1'b0, -1, 1'b0, "mask101");

        fill(1'b0, 1'b0);
        busy_plan[1] = 5;
        do_op(2, 1'b1, -1, 1'b0, "busy5");

        fill(1'b0, 1'b0);
        exc_plan[2] = 1'b1;
        do_op(4, 1'b1, -1, 1'b0, "exc2");

        fill(1'b0, 1'b0);
        mk[1] = 1'b0; exc_plan[1] = 1'b1;
        do_op(3, 1'b0, -1, 1'b0, "exc_masked");

        fill(1'b0, 1'b0);
        busy_plan[1] = 3;
        do_op(4, 1'b1, 1, 1'b0, "flush_wait");

        reset_log();
        op_vl = 0;
        bus.vl = VW'(5); bus.start = 1'b1; bus.flush = 1'b1;
        step();
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_ready", 64'(bus.ready), 64'd1);
        repeat (4) step();
        chk("flush_start_reads", 64'(reads), 64'd0);
        chk("flush_start_starts", 64'(starts), 64'd0);

        fill(1'b1, 1'b0);
        do_op(40, 1'b0, -1, 1'b0, "clamp40");
        fill(1'b0, 1'b0);
        do_op(32, 1'b1, -1, 1'b0, "vlmax");

        fill(1'b1, 1'b1);
        do_op(12, 1'b0, -1, 1'b1, "start_noise");

        fill(1'b0, 1'b0);
        busy_plan[2] = 2;
        reset_log();
        op_vl = 8;
        bus.vl = VW'(8); bus.vm = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        step();
        check_reset_outputs("midop_rst");
        rst = 1'b0;
        lw = 1'b0; rd_pend = 1'b0; busy_rem = 0;
        op_vl = 0;
        step();
        fill(1'b1, 1'b0);
        do_op(5, 1'b0, -1, 1'b0, "after_rst");

        for (int k = 0; k < 15; k++) begin
            fill(1'b1, 1'b1);
            do_op(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), -1,
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
